// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader
//   Loads a serial bitstream into a chain of scan/configurable flip-flops.
//   Sequence: clear the chain, then shift exactly CHAIN_LEN bits under a
//   valid/ready handshake, then wait a settle time, then release CFGE.
//
// Ports
//   CK, RST      clock, synchronous active-high reset
//   start        begin (re)configuration (IDLE/ACTIVE only)
//   abort        cancel the load in progress (CLEAR/SHIFT/SETTLE only)
//   bit_valid    bit_in carries a valid bit
//   bit_in       next bitstream bit (the first bit ends in the last FF)
//   bit_ready    a bit is accepted this cycle (combinational: state == SHIFT)
//   chain_rst    active-high reset to the chain
//   chain_ce     one-cycle shift strobe to the chain
//   SE, SI       scan enable / scan data to the chain head
//   CFGE         configuration release
//   busy         high while clearing, shifting or settling
//   done         one-cycle pulse when CFGE rises
//   err          one-cycle pulse when a load is aborted
//   bits_loaded  number of bits accepted in the current/last load
module cfg_chain_loader #(
    parameter int unsigned CHAIN_LEN     = 64,
    parameter int unsigned CLR_CYCLES    = 2,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = $clog2(CHAIN_LEN + 1)
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             start,
    input  logic             abort,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             bit_ready,
    output logic             chain_rst,
    output logic             chain_ce,
    output logic             SE,
    output logic             SI,
    output logic             CFGE,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] bits_loaded
);

    localparam int unsigned TMR_MAX = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT  = CNT_W'(CHAIN_LEN);
    localparam logic [TMR_W-1:0] CLR_LAST    = TMR_W'(CLR_CYCLES - 1);
    // SETTLE spends one cycle on the final strobe plus SETTLE_CYCLES idle cycles.
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_SETTLE,
        S_ACTIVE
    } state_e;

    state_e           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] bits_loaded_q, bits_loaded_d;
    logic             chain_rst_q, chain_rst_d;
    logic             chain_ce_q, chain_ce_d;
    logic             se_q, se_d;
    logic             si_q, si_d;
    logic             cfge_q, cfge_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             accept;

    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q;
        bits_loaded_d = bits_loaded_q;
        si_d          = si_q;
        err_d         = 1'b0;
        accept        = 1'b0;

        case (state_q)
            S_IDLE, S_ACTIVE: begin
                if (start) begin
                    state_d       = S_CLEAR;
                    tmr_d         = '0;
                    bits_loaded_d = '0;
                end
            end
            S_CLEAR: begin
                if (abort) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (tmr_q == CLR_LAST) begin
                    state_d = S_SHIFT;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_SHIFT: begin
                // abort takes priority over a bit offered in the same cycle
                if (abort) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (bit_valid) begin
                    accept = 1'b1;
                    si_d   = bit_in;
                    if (bits_loaded_q != FULL_COUNT) begin
                        bits_loaded_d = bits_loaded_q + CNT_W'(1);
                    end
                    if (bits_loaded_q == LAST_BIT) begin
                        state_d = S_SETTLE;
                        tmr_d   = '0;
                    end
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (tmr_q == SETTLE_LAST) begin
                    state_d = S_ACTIVE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered outputs are a function of the state being entered, so they
        // line up with the state they describe rather than lagging by a cycle.
        chain_rst_d = (state_d == S_CLEAR);
        chain_ce_d  = accept;
        se_d        = accept | (state_d == S_SHIFT);
        cfge_d      = (state_d == S_ACTIVE);
        done_d      = (state_d == S_ACTIVE) && (state_q != S_ACTIVE);
        busy_d      = (state_d == S_CLEAR) || (state_d == S_SHIFT) || (state_d == S_SETTLE);
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q       <= S_IDLE;
            tmr_q         <= '0;
            bits_loaded_q <= '0;
            chain_rst_q   <= 1'b0;
            chain_ce_q    <= 1'b0;
            se_q          <= 1'b0;
            si_q          <= 1'b0;
            cfge_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            bits_loaded_q <= bits_loaded_d;
            chain_rst_q   <= chain_rst_d;
            chain_ce_q    <= chain_ce_d;
            se_q          <= se_d;
            si_q          <= si_d;
            cfge_q        <= cfge_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign bit_ready   = (state_q == S_SHIFT);
    assign chain_rst   = chain_rst_q;
    assign chain_ce    = chain_ce_q;
    assign SE          = se_q;
    assign SI          = si_q;
    assign CFGE        = cfge_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign bits_loaded = bits_loaded_q;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// tb_cfg_chain_loader
//   Scoreboard bench for cfg_chain_loader with an 8-bit chain. The driver
//   pushes each bit it hands over, plus expected done/err events, into queues;
//   a negedge monitor pops them as the DUT strobes, completes or aborts.
module tb_cfg_chain_loader;

    localparam int CL  = 8;
    localparam int CLR = 2;
    localparam int STL = 2;
    localparam int CW  = $clog2(CL + 1);

    logic          CK = 1'b0;
    logic          RST, start, abort, bit_valid, bit_in;
    logic          bit_ready, chain_rst, chain_ce, SE, SI, CFGE, busy, done, err;
    logic [CW-1:0] bits_loaded;

    cfg_chain_loader #(
        .CHAIN_LEN    (CL),
        .CLR_CYCLES   (CLR),
        .SETTLE_CYCLES(STL),
        .CNT_W        (CW)
    ) dut (
        .CK         (CK),
        .RST        (RST),
        .start      (start),
        .abort      (abort),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .bit_ready  (bit_ready),
        .chain_rst  (chain_rst),
        .chain_ce   (chain_ce),
        .SE         (SE),
        .SI         (SI),
        .CFGE       (CFGE),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .bits_loaded(bits_loaded)
    );

    always #5 CK = ~CK;

    int cyc = 0;
    always @(posedge CK) cyc++;

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard
    bit sb_bits[$];
    int sb_err[$];
    int sb_done    = 0;
    bit mon_en     = 1'b0;
    int rst_run    = 0;
    int last_strobe = 0;
    bit prev_si    = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    // Monitor
    always @(negedge CK) begin
        if (mon_en) begin
            if (chain_ce || chain_rst) check("ce_rst_exclusive", 32'(chain_ce & chain_rst), 0);
            if (chain_rst) rst_run++;
            else if (rst_run != 0) begin
                if (!err) check("clear_len", rst_run, CLR);
                rst_run = 0;
            end
            if (chain_ce) begin
                check("strobe_se", SE, 1);
                check("strobe_pending", 32'(sb_bits.size() > 0), 1);
                if (sb_bits.size() > 0) check("si_bit", SI, 32'(sb_bits.pop_front()));
                last_strobe = cyc;
            end else if (SE) begin
                check("si_hold", SI, 32'(prev_si));
            end
            if (done) begin
                check("done_expected", 32'(sb_done > 0), 1);
                if (sb_done > 0) sb_done--;
                check("done_cfge", CFGE, 1);
                check("done_bits", bits_loaded, CL);
                check("done_latency", cyc - last_strobe, STL + 1);
                check("done_all_bits", sb_bits.size(), 0);
            end
            if (err) begin
                check("err_expected", 32'(sb_err.size() > 0), 1);
                if (sb_err.size() > 0) check("err_bits", bits_loaded, sb_err.pop_front());
                check("err_outputs", {CFGE, SE, chain_ce, chain_rst}, 0);
                check("err_all_bits", sb_bits.size(), 0);
            end
            prev_si = SI;
        end
    end

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic do_reset(input int n);
        mon_en    = 1'b0;
        RST       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        repeat (n) tick();
        check("reset_outputs", {bit_ready, chain_rst, chain_ce, SE, SI, CFGE, busy, done, err}, 0);
        check("reset_bits", bits_loaded, 0);
        sb_bits.delete();
        sb_err.delete();
        sb_done = 0;
        rst_run = 0;
        prev_si = 1'b0;
        RST     = 1'b0;
        mon_en  = 1'b1;
    endtask

    // Issue start (optionally together with abort) and wait for bit_ready.
    task automatic start_load(input bit with_abort, output bit ok);
        int lat;
        start = 1'b1;
        abort = with_abort;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_cfge_low", CFGE, 0);
        check("start_busy", busy, 1);
        check("start_bits_clr", bits_loaded, 0);
        check("start_no_err", err, 0);
        lat = 1;
        while (!bit_ready && lat < 20) begin
            tick();
            lat++;
        end
        check("ready_latency", lat, CLR + 1);
        ok = bit_ready;
    endtask

    // mode 0: valid held, 1: valid every other cycle, 2: random valid.
    // Bits go out MSB first so the first bit sent is data[7].
    task automatic feed(input logic [7:0] data, input int mode, input int nbits, input bit poke_start);
        int idx   = 0;
        int guard = 0;
        while (idx < nbits && guard < 200) begin
            case (mode)
                0:       bit_valid = 1'b1;
                1:       bit_valid = (guard % 2 == 0);
                default: bit_valid = ($urandom_range(0, 3) != 0);
            endcase
            bit_in = bit_valid ? data[7 - idx] : 1'($urandom_range(0, 1));
            start  = poke_start && (idx == 3);
            if (bit_valid && bit_ready) begin
                sb_bits.push_back(bit_in);
                idx++;
            end
            tick();
            guard++;
        end
        start     = 1'b0;
        bit_valid = 1'b0;
        check("feed_complete", idx, nbits);
    endtask

    task automatic full_load(input logic [7:0] data, input int mode, input bit poke,
                             input bit tail_valid, input bit with_abort);
        bit ok;
        int g;
        start_load(with_abort, ok);
        if (!ok) return;
        sb_done++;
        feed(data, mode, CL, poke);
        // Now in the settle window: extra bits and start must be ignored.
        bit_valid = tail_valid;
        start     = poke;
        for (int i = 0; i < STL + 1; i++) begin
            check("settle_no_ready", bit_ready, 0);
            tick();
            start = 1'b0;
        end
        bit_valid = 1'b0;
        g = 0;
        while (!CFGE && g < 10) begin
            tick();
            g++;
        end
        check("cfge_rise", CFGE, 1);
        check("active_bits", bits_loaded, CL);
        check("active_se_low", SE, 0);
        check("active_not_busy", busy, 0);
    endtask

    initial begin
        bit   ok;
        logic [7:0] rnd;

        do_reset(2);

        // abort in IDLE is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_err", err, 0);
        check("idle_abort_busy", busy, 0);

        // 0xA5 with valid held
        full_load(8'hA5, 0, 1'b0, 1'b1, 1'b0);

        // abort in ACTIVE is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("active_abort_cfge", CFGE, 1);
        check("active_abort_err", err, 0);

        // reload from ACTIVE, valid toggling, start poked mid-shift and in settle
        full_load(8'hA5, 1, 1'b1, 1'b1, 1'b0);

        // start and abort together from ACTIVE: start wins
        full_load(8'h3C, 0, 1'b0, 1'b0, 1'b1);

        // abort after 5 accepted bits
        start_load(1'b0, ok);
        feed(8'hD2, 0, 5, 1'b0);
        abort = 1'b1;
        sb_err.push_back(5);
        tick();
        abort = 1'b0;
        check("abort_err", err, 1);
        check("abort_cfge", CFGE, 0);
        check("abort_se", SE, 0);
        check("abort_bits", bits_loaded, 5);
        check("abort_busy", busy, 0);
        bit_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("abort_no_ready", bit_ready, 0);
            tick();
        end
        bit_valid = 1'b0;
        check("err_one_cycle", err, 0);

        // abort during CLEAR
        start = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b1;
        sb_err.push_back(0);
        tick();
        abort = 1'b0;
        check("clear_abort_err", err, 1);
        check("clear_abort_rst", chain_rst, 0);

        // randomized loads
        for (int n = 0; n < 5; n++) begin
            rnd = 8'($urandom);
            full_load(rnd, 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        // reset held 3 cycles in the middle of SHIFT
        start_load(1'b0, ok);
        feed(8'h96, 0, 3, 1'b0);
        do_reset(3);

        // recovery after reset
        full_load(8'h5A, 2, 1'b0, 1'b1, 1'b0);

        tick();
        tick();
        check("sb_drained", sb_bits.size() + sb_err.size() + sb_done, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required to finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
